// File: rtl/coin_score_tracker.sv
// coin_score_tracker
//   Turns coin-detector touch levels into one-shot collection events, issues a
//   tile-clear request per collected coin over valid/ready, keeps a saturating
//   score and drives the board LEDs (flash after each pickup, solid on win).
//
// Ports:
//   vga_clock     in   clock, all logic on rising edge
//   reset         in   synchronous active-high reset
//   touch         in   [NUM_COINS] per-coin overlap level
//   frame_tick    in   one-cycle pulse per video frame
//   clr_valid     out  tile-clear request valid
//   clr_index     out  [3] coin index to clear, stable while clr_valid
//   clr_ready     in   background owner accepts when clr_valid && clr_ready
//   collected     out  [NUM_COINS] coins whose clear has been accepted
//   score         out  [SCORE_WIDTH] saturating running score
//   all_collected out  every coin collected
//   leds          out  [10] board LEDs
//
// LED FSM states:
//   state | meaning
//   IDLE  | leds show collected, flash bit off
//   FLASH | leds show collected, leds[9] toggles each frame tick
//   WIN   | every coin collected, all LEDs lit until reset
module coin_score_tracker #(
  parameter int NUM_COINS    = 2,
  parameter int COIN_VALUE   = 1,
  parameter int SCORE_WIDTH  = 8,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                   vga_clock,
  input  logic                   reset,
  input  logic [NUM_COINS-1:0]   touch,
  input  logic                   frame_tick,
  output logic                   clr_valid,
  output logic [2:0]             clr_index,
  input  logic                   clr_ready,
  output logic [NUM_COINS-1:0]   collected,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   all_collected,
  output logic [9:0]             leds
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, FLASH, WIN} led_state_t;

  logic [NUM_COINS-1:0]   touch_q;
  logic [NUM_COINS-1:0]   pending;
  logic [NUM_COINS-1:0]   rise;
  logic [NUM_COINS-1:0]   acc_mask;
  logic [NUM_COINS-1:0]   pending_next;
  logic [NUM_COINS-1:0]   collected_next;
  logic                   accept;
  logic                   completes;
  logic [2:0]             first_idx;
  logic [SCORE_WIDTH:0]   score_sum;
  logic [SCORE_WIDTH-1:0] score_sat;

  led_state_t state_q, state_d;
  logic [CW-1:0] flash_cnt_q, flash_cnt_d;
  logic          phase_q, phase_d;
  logic [9:0]    leds_d;

  always_comb begin
    accept    = clr_valid & clr_ready;
    rise      = touch & ~touch_q;
    acc_mask  = '0;
    first_idx = 3'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      acc_mask[i] = accept && (clr_index == 3'(i));
    end
    // Walk downward so the lowest set pending bit wins.
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = 3'(i);
    end
    // A rise on an already collected coin is dropped; one on a pending coin is
    // absorbed because its bit is already set.
    pending_next   = (pending | (rise & ~collected)) & ~acc_mask;
    collected_next = collected | acc_mask;
    completes      = accept && (&collected_next);
    score_sum      = {1'b0, score} + (SCORE_WIDTH + 1)'(COIN_VALUE);
    score_sat      = score_sum[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : score_sum[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      touch_q       <= '0;
      pending       <= '0;
      collected     <= '0;
      score         <= '0;
      clr_valid     <= 1'b0;
      clr_index     <= 3'd0;
      all_collected <= 1'b0;
    end else begin
      touch_q       <= touch;
      pending       <= pending_next;
      collected     <= collected_next;
      all_collected <= &collected_next;
      // Issue only from an idle channel, which forces a gap cycle between requests.
      if (accept) begin
        clr_valid <= 1'b0;
        score     <= score_sat;
      end else if (!clr_valid && (|pending)) begin
        clr_valid <= 1'b1;
        clr_index <= first_idx;
      end
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      flash_cnt_q <= '0;
      phase_q     <= 1'b0;
      leds        <= '0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      leds        <= leds_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    leds_d      = '0;
    case (state_q)
      IDLE, FLASH: begin
        // An acceptance overrides a coincident frame tick.
        if (accept) begin
          if (completes) begin
            state_d = WIN;
          end else begin
            state_d     = FLASH;
            flash_cnt_d = CW'(FLASH_FRAMES);
            phase_d     = 1'b1;
          end
        end else if (state_q == FLASH && frame_tick) begin
          // Count runs down one frame per tick; the tick that finds it at zero
          // ends the flash, so the last lit phase lasts a full frame.
          if (flash_cnt_q == '0) begin
            state_d = IDLE;
            phase_d = 1'b0;
          end else begin
            flash_cnt_d = flash_cnt_q - 1'b1;
            phase_d     = ~phase_q;
          end
        end
      end
      WIN:     state_d = WIN;
      default: state_d = IDLE;
    endcase

    // LEDs are registered from next-state values so they line up with collected.
    if (state_d == WIN) begin
      leds_d = 10'h3FF;
    end else begin
      leds_d[NUM_COINS-1:0] = collected_next;
      if (state_d == FLASH) leds_d[9] = phase_d;
    end
  end

endmodule

// File: tb/tb_coin_score_tracker.sv
// Directed bench for coin_score_tracker: one instance with a short flash
// (FLASH_FRAMES=4) and one with a large coin value to exercise saturation.
module tb_coin_score_tracker;

  logic       vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  logic       reset, frame_tick, clr_ready, clr_valid, all_collected;
  logic [1:0] touch, collected;
  logic [2:0] clr_index;
  logic [7:0] score;
  logic [9:0] leds;

  logic       s_reset, s_frame_tick, s_clr_ready, s_clr_valid, s_all_collected;
  logic [1:0] s_touch, s_collected;
  logic [2:0] s_clr_index;
  logic [7:0] s_score;
  logic [9:0] s_leds;

  int checks = 0;
  int errors = 0;

  coin_score_tracker #(.NUM_COINS(2), .COIN_VALUE(1), .SCORE_WIDTH(8), .FLASH_FRAMES(4)) dut (
    .vga_clock(vga_clock), .reset(reset), .touch(touch), .frame_tick(frame_tick),
    .clr_valid(clr_valid), .clr_index(clr_index), .clr_ready(clr_ready),
    .collected(collected), .score(score), .all_collected(all_collected), .leds(leds)
  );

  coin_score_tracker #(.NUM_COINS(2), .COIN_VALUE(200), .SCORE_WIDTH(8), .FLASH_FRAMES(4)) dut_sat (
    .vga_clock(vga_clock), .reset(s_reset), .touch(s_touch), .frame_tick(s_frame_tick),
    .clr_valid(s_clr_valid), .clr_index(s_clr_index), .clr_ready(s_clr_ready),
    .collected(s_collected), .score(s_score), .all_collected(s_all_collected), .leds(s_leds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clock);
    #1;
  endtask

  initial begin
    int reqs;
    int bad;
    logic [9:0] flash_exp [5];
    flash_exp[0] = 10'h001; flash_exp[1] = 10'h201; flash_exp[2] = 10'h001;
    flash_exp[3] = 10'h201; flash_exp[4] = 10'h001;

    reset = 1'b1; touch = '0; frame_tick = 1'b0; clr_ready = 1'b0;
    s_reset = 1'b1; s_touch = '0; s_frame_tick = 1'b0; s_clr_ready = 1'b0;
    step(); step();
    reset = 1'b0; s_reset = 1'b0;

    check("rst_score", score, 0);
    check("rst_collected", collected, 0);
    check("rst_clr_valid", clr_valid, 0);
    check("rst_leds", leds, 0);
    check("rst_all_collected", all_collected, 0);

    // Coin 0 held for 50 cycles with ready tied high: one request only.
    clr_ready = 1'b1;
    touch = 2'b01;
    step();
    check("lat_edge1_valid", clr_valid, 0);
    step();
    check("lat_edge2_valid", clr_valid, 1);
    check("lat_edge2_index", clr_index, 0);
    reqs = 1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (clr_valid) reqs++;
    end
    check("c0_req_count", reqs, 1);
    check("c0_collected", collected, 2'b01);
    check("c0_score", score, 1);
    check("c0_leds_flash", leds, 10'h201);
    check("c0_all_collected", all_collected, 0);

    // Five frame ticks: phase 1 -> 0,1,0,1 then back to IDLE.
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check($sformatf("flash_tick%0d", i + 1), leds, flash_exp[i]);
      step();
    end

    // Re-touch of a collected coin must not raise a request.
    touch = 2'b00;
    step();
    touch = 2'b01;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (clr_valid) reqs++;
    end
    check("retouch_reqs", reqs, 0);
    check("retouch_score", score, 1);

    // Coin 1 with backpressure for 20 cycles.
    clr_ready = 1'b0;
    touch = 2'b10;
    step(); step();
    check("hold_valid", clr_valid, 1);
    check("hold_index", clr_index, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clr_valid !== 1'b1 || clr_index !== 3'd1 || score !== 8'd1) bad++;
    end
    check("hold_stable_bad_cycles", bad, 0);
    clr_ready = 1'b1;
    step();
    check("hold_accept_valid", clr_valid, 0);
    check("hold_accept_score", score, 2);
    check("hold_accept_collected", collected, 2'b11);
    check("win_all_collected", all_collected, 1);
    check("win_leds", leds, 10'h3FF);
    touch = 2'b00;
    clr_ready = 1'b0;

    // Simultaneous rises with saturation on the second instance.
    s_clr_ready = 1'b1;
    s_touch = 2'b11;
    step();
    check("sat_e1_valid", s_clr_valid, 0);
    step();
    check("sat_e2_valid", s_clr_valid, 1);
    check("sat_e2_index", s_clr_index, 0);
    step();
    check("sat_e3_gap_valid", s_clr_valid, 0);
    check("sat_e3_score", s_score, 200);
    check("sat_e3_collected", s_collected, 2'b01);
    step();
    check("sat_e4_valid", s_clr_valid, 1);
    check("sat_e4_index", s_clr_index, 1);
    step();
    check("sat_e5_score", s_score, 255);
    check("sat_e5_all_collected", s_all_collected, 1);
    check("sat_e5_leds", s_leds, 10'h3FF);

    // Reset while a request is outstanding; ready rises on the reset edge.
    reset = 1'b1;
    step();
    reset = 1'b0;
    touch = 2'b01;
    step(); step();
    check("mid_rst_valid_before", clr_valid, 1);
    clr_ready = 1'b1;
    reset = 1'b1;
    step();
    check("mid_rst_valid", clr_valid, 0);
    check("mid_rst_collected", collected, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_leds", leds, 0);
    check("mid_rst_all_collected", all_collected, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
